quicksort_host: RTL and testbench

//  Stream front-end for quicksort. It wraps quicksort's toggle command interface (push/pop/clear/sort) in valid/ready streams.
//  It takes one batch of words on s_* (closed by s_last), then clears, loads and sorts the engine.
//  It then drains the sorted words in ascending order on m_*, with m_last on the final word.
//  It sits directly upstream and downstream of quicksort and is the only driver of its command inputs.

---
 rtl/quicksort_pkg.sv | 50 +++++
 rtl/qs_cmd_issuer.sv | 68 ++++++
 rtl/quicksort_host.sv | 199 +++++++++++++++++++
 tb/tb_quicksort_host.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quicksort_pkg.sv
// quicksort_pkg
// Shared definitions for the quicksort stream host:
//   - GRAY() macro (binary to Gray code)
//   - host FSM states ST_IDLE..ST_POP
//   - command selector for the single command issuer
//   - default geometry plus helpers deriving capacity and counter width
//     from the data/pointer MSB parameters

`ifndef QUICKSORT_PKG_GRAY
`define QUICKSORT_PKG_GRAY
`define GRAY(x) ((x) ^ ((x) >> 1))
`endif

package quicksort_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_PUSH,
        ST_SORT,
        ST_FETCH,
        ST_OUT,
        ST_POP
    } host_state_t;

    typedef enum logic [1:0] {
        CMD_CLEAR,
        CMD_PUSH,
        CMD_POP,
        CMD_SORT
    } qs_cmd_t;

    localparam int QS_A_D_MSB  = 7;
    localparam int QS_A_P_MSB  = 3;
    localparam int QS_CAPACITY = (2 ** (QS_A_P_MSB + 1)) - 1;
    localparam int QS_CNT_W    = QS_A_P_MSB + 2;

    // The engine keeps one pointer value in reserve, so it holds one word fewer
    // than its pointer range.
    function automatic int qs_capacity(input int p_msb);
        return (2 ** (p_msb + 1)) - 1;
    endfunction

    // One bit wider than the pointer, so a count equal to capacity never wraps.
    function automatic int qs_cnt_width(input int p_msb);
        return p_msb + 2;
    endfunction

endpackage

// File: rtl/qs_cmd_issuer.sv
// qs_cmd_issuer
// Turns a one-cycle request into a toggle on one of the four quicksort
// command levels. It then waits SETTLE cycles and after that waits for
// qs_idle. Only one command is in flight; done is high for the single cycle
// in which the wait completes.
// Ports:
//   clk, rst                            clock, asynchronous active-high reset
//   req, cmd                            start a command (one cycle) and which one
//   qs_idle                             engine idle status
//   done                                wait complete (combinational, one cycle)
//   qs_push, qs_pop, qs_clear, qs_sort  toggle command levels to quicksort

module qs_cmd_issuer
    import quicksort_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    req,
    input  qs_cmd_t cmd,
    input  logic    qs_idle,
    output logic    done,
    output logic    qs_push,
    output logic    qs_pop,
    output logic    qs_clear,
    output logic    qs_sort
);

    localparam int SW = $clog2(SETTLE + 1);

    logic [SW-1:0] settle_cnt;
    logic          waiting;

    // done is combinational so that the host can issue the next command on the
    // same edge that retires the current one.
    assign done = waiting && (settle_cnt == '0) && qs_idle;

    // A request flips exactly one toggle level and restarts the settle count.
    // The engine is given SETTLE cycles to see the edge and drop qs_idle.
    // qs_idle is trusted only after that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            waiting    <= 1'b0;
            qs_push    <= 1'b0;
            qs_pop     <= 1'b0;
            qs_clear   <= 1'b0;
            qs_sort    <= 1'b0;
        end else if (req) begin
            waiting    <= 1'b1;
            settle_cnt <= SW'(SETTLE);
            unique case (cmd)
                CMD_CLEAR: qs_clear <= ~qs_clear;
                CMD_PUSH:  qs_push  <= ~qs_push;
                CMD_POP:   qs_pop   <= ~qs_pop;
                CMD_SORT:  qs_sort  <= ~qs_sort;
            endcase
        end else if (waiting) begin
            if (settle_cnt != '0) begin
                settle_cnt <= settle_cnt - SW'(1);
            end else if (qs_idle) begin
                waiting <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/quicksort_host.sv
// quicksort_host
// Stream front-end for the quicksort engine. It collects one batch from s_*
// (closed by s_last), then clears, loads and sorts the engine. It then drains
// the words in ascending order on m_*, with m_last on the final word.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   enable                       a new batch may start only while high
//   s_data/s_valid/s_last/s_ready  input stream
//   m_data/m_valid/m_last/m_ready  sorted output stream
//   qs_rx_data, qs_push/pop/clear/sort  data and toggle commands to quicksort
//   qs_tx_data, qs_idle/full/empty      data and status from quicksort
//   busy                         high whenever the FSM is not in ST_IDLE
//   overflow                     sticky; words were dropped because the engine was full

module quicksort_host
    import quicksort_pkg::*;
#(
    parameter int A_D_MSB = QS_A_D_MSB,
    parameter int A_P_MSB = QS_A_P_MSB,
    parameter int SETTLE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [A_D_MSB:0] s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [A_D_MSB:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [A_D_MSB:0] qs_rx_data,
    output logic             qs_push,
    output logic             qs_pop,
    output logic             qs_clear,
    output logic             qs_sort,
    input  logic [A_D_MSB:0] qs_tx_data,
    input  logic             qs_idle,
    input  logic             qs_full,
    input  logic             qs_empty,
    output logic             busy,
    output logic             overflow
);

    localparam int CNT_W    = qs_cnt_width(A_P_MSB);
    localparam int CAPACITY = qs_capacity(A_P_MSB);

    host_state_t      state;
    logic [CNT_W-1:0] n_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic             last_seen;
    logic             cmd_req;
    logic             cmd_done;
    qs_cmd_t          cmd_sel;
    logic             at_capacity;
    logic             unused_empty;

    // Occupancy comes from n_cnt, so the engine's empty flag is not needed.
    // The local capacity compare backs up qs_full so that n_cnt cannot pass
    // the engine's capacity.
    assign unused_empty = qs_empty;
    assign at_capacity  = qs_full || (n_cnt == CNT_W'(CAPACITY));
    assign s_ready      = (state == ST_LOAD);
    assign busy         = (state != ST_IDLE);

    qs_cmd_issuer #(
        .SETTLE   (SETTLE)
    ) u_issuer (
        .clk      (clk),
        .rst      (rst),
        .req      (cmd_req),
        .cmd      (cmd_sel),
        .qs_idle  (qs_idle),
        .done     (cmd_done),
        .qs_push  (qs_push),
        .qs_pop   (qs_pop),
        .qs_clear (qs_clear),
        .qs_sort  (qs_sort)
    );

    // A command is requested on the same edge that enters its waiting state.
    // So the toggle flips as the FSM arrives, and the next word is ready
    // SETTLE+2 cycles after an output handshake.
    always_comb begin
        cmd_req = 1'b0;
        cmd_sel = CMD_CLEAR;
        case (state)
            ST_IDLE: begin
                if (enable && s_valid) begin
                    cmd_req = 1'b1;
                    cmd_sel = CMD_CLEAR;
                end
            end
            ST_LOAD: begin
                if (s_valid) begin
                    if (!at_capacity) begin
                        cmd_req = 1'b1;
                        cmd_sel = CMD_PUSH;
                    end else if (s_last && (n_cnt != '0)) begin
                        cmd_req = 1'b1;
                        cmd_sel = CMD_SORT;
                    end
                end
            end
            ST_PUSH: begin
                if (cmd_done && last_seen) begin
                    cmd_req = 1'b1;
                    cmd_sel = CMD_SORT;
                end
            end
            ST_OUT: begin
                if (m_ready && !m_last) begin
                    cmd_req = 1'b1;
                    cmd_sel = CMD_POP;
                end
            end
            default: ;
        endcase
    end

    // Host FSM. The last sorted word is never popped; it stays in the engine
    // until the clear at the start of the next batch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            n_cnt      <= '0;
            out_cnt    <= '0;
            last_seen  <= 1'b0;
            overflow   <= 1'b0;
            qs_rx_data <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable && s_valid) begin
                        overflow <= 1'b0;
                        n_cnt    <= '0;
                        state    <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (cmd_done) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (s_valid) begin
                        if (!at_capacity) begin
                            qs_rx_data <= s_data;
                            n_cnt      <= n_cnt + CNT_W'(1);
                            last_seen  <= s_last;
                            state      <= ST_PUSH;
                        end else begin
                            overflow <= 1'b1;
                            if (s_last) begin
                                state <= (n_cnt == '0) ? ST_IDLE : ST_SORT;
                            end
                        end
                    end
                end
                ST_PUSH: begin
                    if (cmd_done) begin
                        state <= last_seen ? ST_SORT : ST_LOAD;
                    end
                end
                ST_SORT: begin
                    if (cmd_done) begin
                        out_cnt <= '0;
                        state   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    m_data  <= qs_tx_data;
                    m_valid <= 1'b1;
                    m_last  <= (out_cnt == (n_cnt - CNT_W'(1)));
                    state   <= ST_OUT;
                end
                ST_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        state   <= m_last ? ST_IDLE : ST_POP;
                    end
                end
                ST_POP: begin
                    if (cmd_done) begin
                        out_cnt <= out_cnt + CNT_W'(1);
                        state   <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quicksort_host.sv
// tb_quicksort_host
// Self-checking bench for quicksort_host. A small behavioural stand-in for the
// quicksort engine answers the toggle commands. The expected output of each
// batch is the first CAP words of that batch in ascending order, with the last
// word of that list marked.

module tb_quicksort_host;
    import quicksort_pkg::*;

    typedef logic [7:0] byteq_t[$];

    localparam int CAP = QS_CAPACITY;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic [7:0] qs_rx_data;
    logic       qs_push;
    logic       qs_pop;
    logic       qs_clear;
    logic       qs_sort;
    logic [7:0] qs_tx_data = 8'd0;
    logic       qs_idle    = 1'b1;
    logic       qs_full    = 1'b0;
    logic       qs_empty   = 1'b1;
    logic       busy;
    logic       overflow;

    int tests_run = 0;
    int failures  = 0;

    byteq_t      exp_q;
    bit          exp_last_q[$];
    bit          exp_overflow;
    logic [QS_CNT_W-1:0] out_count;
    logic [7:0]  last_out;

    int clear_cnt = 0;
    int push_cnt  = 0;
    int pop_cnt   = 0;
    int sort_cnt  = 0;

    bit stall_pending = 0;
    int stall_done    = 0;

    quicksort_host #(
        .A_D_MSB    (7),
        .A_P_MSB    (3),
        .SETTLE     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .qs_rx_data (qs_rx_data),
        .qs_push    (qs_push),
        .qs_pop     (qs_pop),
        .qs_clear   (qs_clear),
        .qs_sort    (qs_sort),
        .qs_tx_data (qs_tx_data),
        .qs_idle    (qs_idle),
        .qs_full    (qs_full),
        .qs_empty   (qs_empty),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: dropped words are the ones arriving after the engine is full,
    // so the output is the sorted prefix of at most CAP words.
    function automatic byteq_t modelSort(input byteq_t words);
        byteq_t r;
        for (int i = 0; i < words.size() && i < CAP; i++) r.push_back(words[i]);
        r.sort();
        return r;
    endfunction

    // Engine stand-in. Each toggle makes it busy for a few cycles. That is
    // longer than SETTLE, so the host has to wait on qs_idle. The operation
    // takes effect when it goes idle again.
    int      busy_left = 0;
    qs_cmd_t pend_op   = CMD_CLEAR;
    logic [7:0] pend_data;
    byteq_t  qmem;
    logic    prev_push = 0, prev_pop = 0, prev_clear = 0, prev_sort = 0;

    task automatic startOp(input qs_cmd_t op, input int dur);
        checkOutput("single_cmd_in_flight", busy_left, 0);
        pend_op   = op;
        pend_data = qs_rx_data;
        busy_left = dur;
        qs_idle   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            qmem.delete();
            busy_left  = 0;
            qs_idle    = 1'b1;
            prev_push  = 1'b0;
            prev_pop   = 1'b0;
            prev_clear = 1'b0;
            prev_sort  = 1'b0;
        end else begin
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    case (pend_op)
                        CMD_CLEAR: qmem.delete();
                        CMD_PUSH:  if (qmem.size() < CAP) qmem.push_back(pend_data);
                        CMD_POP:   if (qmem.size() > 0) void'(qmem.pop_front());
                        CMD_SORT:  qmem.sort();
                    endcase
                    qs_idle = 1'b1;
                end
            end
            if (qs_clear != prev_clear) begin clear_cnt++; startOp(CMD_CLEAR, 6); end
            if (qs_push  != prev_push)  begin push_cnt++;  startOp(CMD_PUSH, 6);  end
            if (qs_pop   != prev_pop)   begin pop_cnt++;   startOp(CMD_POP, 6);   end
            if (qs_sort  != prev_sort)  begin sort_cnt++;  startOp(CMD_SORT, 10); end
            prev_clear = qs_clear;
            prev_push  = qs_push;
            prev_pop   = qs_pop;
            prev_sort  = qs_sort;
        end
        qs_full    = (qmem.size() >= CAP);
        qs_empty   = (qmem.size() == 0);
        qs_tx_data = (qmem.size() > 0) ? qmem[0] : 8'd0;
    end

    // Compare process: every handshake against the reference queue, and every
    // stalled cycle against the word presented before the stall.
    bit         prev_hold = 0;
    logic [7:0] hold_data;
    logic       hold_last;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                checkOutput("hold_valid", m_valid, 1);
                checkOutput("hold_data", m_data, hold_data);
                checkOutput("hold_last", m_last, hold_last);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_word", exp_q.size(), 1);
                end else begin
                    checkOutput("m_data", m_data, exp_q[0]);
                    checkOutput("m_last", m_last, exp_last_q[0]);
                    void'(exp_q.pop_front());
                    void'(exp_last_q.pop_front());
                end
                out_count = out_count + 1'b1;
                last_out  = m_data;
            end
            prev_hold = m_valid && !m_ready;
            hold_data = m_data;
            hold_last = m_last;
        end
    end

    // Sink: always ready, except for one 30-cycle stall once a word is
    // presented after at least two have drained.
    initial begin
        m_ready = 1'b1;
        forever begin
            int pops_at_stall;
            @(posedge clk);
            #1;
            if (stall_pending && m_valid && out_count >= 2) begin
                m_ready       = 1'b0;
                pops_at_stall = pop_cnt;
                repeat (30) @(posedge clk);
                #1;
                checkOutput("stall_no_pop", pop_cnt, pops_at_stall);
                m_ready       = 1'b1;
                stall_pending = 0;
                stall_done++;
            end
        end
    end

    task automatic applyStimulus(input byteq_t words, input bit drop_enable);
        byteq_t expv;
        int     w;
        expv = modelSort(words);
        for (int i = 0; i < expv.size(); i++) begin
            exp_q.push_back(expv[i]);
            exp_last_q.push_back(i == expv.size() - 1);
        end
        exp_overflow = (words.size() > CAP);
        out_count    = '0;
        for (int i = 0; i < words.size(); i++) begin
            s_data  = words[i];
            s_valid = 1'b1;
            s_last  = (i == words.size() - 1);
            w = 0;
            @(negedge clk);
            while (!s_ready && w < 3000) begin
                @(negedge clk);
                w++;
            end
            checkOutput("s_ready_wait", s_ready, 1);
            if (!s_ready) break;
            @(posedge clk);
            #1;
            if (drop_enable && i == 0) enable = 1'b0;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        enable  = 1'b1;
    endtask

    task automatic waitDrain(input string name);
        int w = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        checkOutput({name, "_idle"}, busy, 0);
        checkOutput({name, "_drained"}, exp_q.size(), 0);
        checkOutput({name, "_overflow"}, overflow, exp_overflow);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        byteq_t batch, pin, lit;
        int     p0, c0, s0, u0, w;

        rst     = 1'b1;
        enable  = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        s_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_s_ready", s_ready, 0);
        checkOutput("reset_m_valid", m_valid, 0);
        checkOutput("reset_m_last", m_last, 0);
        checkOutput("reset_m_data", m_data, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_toggles", {qs_push, qs_pop, qs_clear, qs_sort}, 0);
        checkOutput("reset_rx_data", qs_rx_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] pinning the reference model");
        batch = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7};
        lit   = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd9};
        pin   = modelSort(batch);
        checkOutput("pin_a_size", pin.size(), 5);
        for (int i = 0; i < 5; i++) checkOutput("pin_a_word", pin[i], lit[i]);
        batch.delete();
        for (int i = 0; i < 20; i++) batch.push_back(8'((i * 37 + 11) % 256));
        pin = modelSort(batch);
        checkOutput("pin_twenty_size", pin.size(), 15);

        $display("[TB] enable low with s_valid high");
        s_valid = 1'b1;
        s_data  = 8'd5;
        repeat (20) begin
            @(negedge clk);
            checkOutput("gated_s_ready", s_ready, 0);
            checkOutput("gated_busy", busy, 0);
        end
        enable = 1'b1;

        $display("[TB] batch 5,3,9,1,7");
        p0 = pop_cnt;
        batch = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7};
        applyStimulus(batch, 0);
        waitDrain("batch_a");
        checkOutput("batch_a_count", out_count, 5);
        checkOutput("batch_a_last_word", last_out, 9);
        checkOutput("batch_a_pops", pop_cnt - p0, 4);

        $display("[TB] single word 42");
        p0 = pop_cnt; c0 = clear_cnt; s0 = sort_cnt; u0 = push_cnt;
        batch = '{8'd42};
        applyStimulus(batch, 0);
        waitDrain("single");
        checkOutput("single_data", last_out, 42);
        checkOutput("single_count", out_count, 1);
        checkOutput("single_pops", pop_cnt - p0, 0);
        checkOutput("single_clears", clear_cnt - c0, 1);
        checkOutput("single_pushes", push_cnt - u0, 1);
        checkOutput("single_sorts", sort_cnt - s0, 1);

        $display("[TB] twenty words into a 15-word engine, enable dropped mid-batch");
        batch.delete();
        for (int i = 0; i < 20; i++) batch.push_back(8'((i * 37 + 11) % 256));
        applyStimulus(batch, 1);
        waitDrain("twenty");
        checkOutput("twenty_count", out_count, 15);
        checkOutput("twenty_overflow", overflow, 1);

        $display("[TB] sink stall mid-drain");
        stall_pending = 1;
        batch = '{8'd200, 8'd15, 8'd99, 8'd15, 8'd0, 8'd255};
        applyStimulus(batch, 0);
        waitDrain("stall");
        checkOutput("stall_happened", stall_done, 1);
        checkOutput("stall_last_word", last_out, 255);
        checkOutput("stall_overflow_cleared", overflow, 0);

        $display("[TB] reset during a push wait");
        u0 = push_cnt;
        s_data  = 8'd10;
        s_last  = 1'b0;
        s_valid = 1'b1;
        w = 0;
        while (push_cnt == u0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        checkOutput("push_seen", push_cnt, u0 + 1);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        s_valid = 1'b0;
        exp_q.delete();
        exp_last_q.delete();
        @(negedge clk);
        checkOutput("rst_toggles", {qs_push, qs_pop, qs_clear, qs_sort}, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_s_ready", s_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        batch = '{8'd2, 8'd1};
        applyStimulus(batch, 0);
        waitDrain("after_reset");
        checkOutput("after_reset_count", out_count, 2);
        checkOutput("after_reset_last_word", last_out, 2);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
